// File: rtl/alu_sched.sv
// alu_sched: shares one combinational 4-bit ALU between two requesters and returns id-tagged results.
// Optional feature macro: ALU_SCHED_FIXED_PRIO_EN (fixed priority, req0 wins ties); default is round-robin.
//
// state  | meaning
// IDLE   | waiting for a request, grant issued combinationally
// EXEC   | op registers drive the ALU, result captured at the edge
// RESP   | response held until rsp_ready
module alu_sched #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] done_cnt0,
    output logic [CNT_W-1:0] done_cnt1
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0] state;
    logic       grant1;
    logic       accept;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    assign grant1 = req1_valid && !req0_valid;
`else
    logic last_grant;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = req1_valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant1;
        end
    end
`endif

    assign accept     = (state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant1;
    assign req1_ready = accept && grant1;
    assign rsp_valid  = (state == S_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= 3'b000;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            done_cnt0  <= '0;
            done_cnt1  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        alu_a   <= grant1 ? req1_a : req0_a;
                        alu_b   <= grant1 ? req1_b : req0_b;
                        alu_sel <= grant1 ? req1_sel : req0_sel;
                        rsp_id  <= grant1;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= (alu_result == '0);
                    state      <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        if (rsp_id) begin
                            done_cnt1 <= done_cnt1 + CNT_ONE;
                        end else begin
                            done_cnt0 <= done_cnt0 + CNT_ONE;
                        end
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched: directed vector table plus hand-written sequences for contention,
// backpressure, reset during EXEC and counter wrap. A small ALU model drives alu_result.
module tb_alu_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_sel;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_zero;
    logic [3:0] rsp_result;
    logic [7:0] done_cnt0, done_cnt1;

    int errors = 0;
    int checks = 0;
    int m0 = 0;
    int m1 = 0;

    alu_sched #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    always_comb begin
        case (alu_sel)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = alu_a ^ alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = alu_b;
            default: alu_result = alu_a;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       id;
        bit [3:0] a;
        bit [3:0] b;
        bit [2:0] sel;
        bit [3:0] exp_result;
        bit       exp_zero;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0 = 0;
        m1 = 0;
    endtask

    task automatic run_op(input bit id, input bit [3:0] a, input bit [3:0] b, input bit [2:0] sel,
                          input bit [3:0] er, input bit ez);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
        #1;
        chk("op_ready_win", id ? req1_ready : req0_ready, 1);
        chk("op_ready_lose", id ? req0_ready : req1_ready, 0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_alu_a", alu_a, a);
        chk("exec_alu_b", alu_b, b);
        chk("exec_alu_sel", alu_sel, sel);
        chk("exec_ready", {req0_ready, req1_ready}, 0);
        step();
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_id", rsp_id, id);
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", rsp_zero, ez);
        if (id) m1++; else m0++;
        step();
        chk("post_rsp_valid", rsp_valid, 0);
        chk("done_cnt0", done_cnt0, m0[7:0]);
        chk("done_cnt1", done_cnt1, m1[7:0]);
    endtask

    task automatic fast_op0();
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2; req0_sel = 3'b000;
        step();
        req0_valid = 1'b0;
        step();
        step();
    endtask

    initial begin
        bit exp_ids [4];
        int cyc;
        bit eid;

        vecs[0] = '{1'b0, 4'h3, 4'h4, 3'b000, 4'h7, 1'b0};
        vecs[1] = '{1'b1, 4'h5, 4'h5, 3'b001, 4'h0, 1'b1};
        vecs[2] = '{1'b1, 4'hF, 4'h1, 3'b000, 4'h0, 1'b1};
        vecs[3] = '{1'b0, 4'h9, 4'h2, 3'b001, 4'h7, 1'b0};
        vecs[4] = '{1'b1, 4'hA, 4'h3, 3'b111, 4'hA, 1'b0};
        vecs[5] = '{1'b0, 4'h0, 4'h0, 3'b111, 4'h0, 1'b1};

        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_a = '0; req1_b = '0; req1_sel = '0;
        step();
        step();
        chk("rst_ready", {req0_ready, req1_ready}, 0);
        chk("rst_alu", {alu_a, alu_b, 1'b0, alu_sel}, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp", {rsp_id, rsp_result, rsp_zero}, 0);
        chk("rst_cnt", {done_cnt0, done_cnt1}, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].exp_result, vecs[i].exp_zero);
        end

        // Contention: both valid continuously from a fresh reset.
`ifdef ALU_SCHED_FIXED_PRIO_EN
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
        do_reset();
        req0_a = 4'h1; req0_b = 4'h1; req0_sel = 3'b000;
        req1_a = 4'h4; req1_b = 4'h1; req1_sel = 3'b000;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (!rsp_valid && cyc < 8) begin
                step();
                cyc++;
            end
            eid = exp_ids[k];
            chk("cont_rsp_valid", rsp_valid, 1);
            chk("cont_gap", cyc, 2);
            chk("cont_id", rsp_id, eid);
            chk("cont_result", rsp_result, eid ? 4'h5 : 4'h2);
            if (eid) m1++; else m0++;
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("cont_cnt0", done_cnt0, m0[7:0]);
        chk("cont_cnt1", done_cnt1, m1[7:0]);

        // Backpressure: response held five cycles while req1 waits.
        step();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3; req0_sel = 3'b000;
        step();
        req0_valid = 1'b0;
        step();
        req1_valid = 1'b1; req1_a = 4'h6; req1_b = 4'h1; req1_sel = 3'b001;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp", {rsp_id, rsp_result, rsp_zero}, {1'b0, 4'h5, 1'b0});
            chk("bp_ready", {req0_ready, req1_ready}, 0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        m0++;
        chk("bp_cnt0", done_cnt0, m0[7:0]);
        chk("bp_req1_ready", req1_ready, 1);
        step();
        req1_valid = 1'b0;
        step();
        chk("bp_next_valid", rsp_valid, 1);
        chk("bp_next_rsp", {rsp_id, rsp_result}, {1'b1, 4'h5});
        step();

        // Reset while EXEC: nothing must survive.
        req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h1; req1_sel = 3'b000;
        step();
        req1_valid = 1'b0;
        chk("rx_in_exec_alu_a", alu_a, 4'h7);
        rst_n = 1'b0;
        #1;
        chk("rx_alu", {alu_a, alu_b, 1'b0, alu_sel}, 0);
        chk("rx_rsp", {rsp_valid, rsp_id, rsp_result, rsp_zero}, 0);
        chk("rx_cnt", {done_cnt0, done_cnt1}, 0);
        step();
        rst_n = 1'b1;
        m0 = 0;
        m1 = 0;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rsp_valid) cyc++;
        end
        chk("rx_no_rsp", cyc, 0);

        // Counter wrap on requester 0.
        for (int k = 0; k < 255; k++) fast_op0();
        chk("wrap_255", done_cnt0, 8'hFF);
        fast_op0();
        chk("wrap_0", done_cnt0, 8'h00);
        chk("wrap_cnt1", done_cnt1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
